cv32e40p_rf_scrub_ctrl: RTL



---
 rtl/cv32e40p_rf_scrub_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cv32e40p_rf_scrub_ctrl.sv
// ---------------------------------------------------------------------------
// cv32e40p_rf_scrub_ctrl
//
// Correction and scrub scheduler for the Hamming-protected integer register
// file. Single-error reports from the three read-port checkers are turned
// into corrected words and queued. Queued words are written back through
// write port B whenever the core leaves that port free. A periodic
// background sweep walks the register file over read port C so latent
// errors get found even in registers the program never reads. Error
// statistics are kept for the debug/status CSRs.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   scrub_en_i          enables the background sweep
//   clear_i             synchronous clear of SEC count, sticky flags, DED addr
//   rd_valid_i[2:0]     read port {c,b,a} carries a real core read
//   raddr_i, rdata_i    read addresses / corrected data, port a in LSBs
//   sec_i, ded_i        single / double error flags per read port
//   core_we_*_i         core write enables and addresses, ports A and B
//   port_c_busy_i       core needs read port C this cycle
//   scrub_re_o          sweep owns read port C this cycle
//   scrub_raddr_o       sweep read address (registered)
//   wb_we_o, wb_waddr_o, wb_wdata_o   correction write on port B
//   sec_count_o         saturating count of SEC events
//   ded_flag_o          sticky: a double error was seen
//   ded_addr_o          address of the first double error since reset/clear
//   ovf_flag_o          sticky: an SEC was dropped because the buffer was full
//   scrub_busy_o        sweep in progress
// ---------------------------------------------------------------------------
module cv32e40p_rf_scrub_ctrl #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 32,
    parameter int DEPTH          = 4,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scrub_en_i,
    input  logic                    clear_i,
    input  logic [2:0]              rd_valid_i,
    input  logic [3*ADDR_WIDTH-1:0] raddr_i,
    input  logic [3*DATA_WIDTH-1:0] rdata_i,
    input  logic [2:0]              sec_i,
    input  logic [2:0]              ded_i,
    input  logic                    core_we_a_i,
    input  logic                    core_we_b_i,
    input  logic [ADDR_WIDTH-1:0]   core_waddr_a_i,
    input  logic [ADDR_WIDTH-1:0]   core_waddr_b_i,
    input  logic                    port_c_busy_i,
    output logic                    scrub_re_o,
    output logic [ADDR_WIDTH-1:0]   scrub_raddr_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_waddr_o,
    output logic [DATA_WIDTH-1:0]   wb_wdata_o,
    output logic [CNT_WIDTH-1:0]    sec_count_o,
    output logic                    ded_flag_o,
    output logic [ADDR_WIDTH-1:0]   ded_addr_o,
    output logic                    ovf_flag_o,
    output logic                    scrub_busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int INT_W = $clog2(SCRUB_INTERVAL + 1);

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } scrubState_e;

    // Unpacked per-port views of the packed read buses
    logic [ADDR_WIDTH-1:0] w_portAddr [3];
    logic [DATA_WIDTH-1:0] w_portData [3];

    logic [2:0] w_effRd;
    logic [2:0] w_effSec;
    logic [2:0] w_effDed;

    logic                  w_candValid;
    logic [ADDR_WIDTH-1:0] w_candAddr;
    logic [DATA_WIDTH-1:0] w_candData;
    logic                  w_candPending;
    logic                  w_candCoreHit;
    logic                  w_enqReq;

    logic [ADDR_WIDTH-1:0] r_bufAddr [DEPTH];
    logic [DATA_WIDTH-1:0] r_bufData [DEPTH];
    logic [DEPTH-1:0]      r_bufValid;
    logic [DEPTH-1:0]      w_validNext;
    logic [DEPTH-1:0]      w_kill;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [OCC_W-1:0]      r_count;

    logic w_headLive;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;

    logic [CNT_WIDTH-1:0]  r_secCnt;
    logic [CNT_WIDTH:0]    w_secSum;
    logic [CNT_WIDTH-1:0]  w_secNext;
    logic                  r_dedFlag;
    logic [ADDR_WIDTH-1:0] r_dedAddr;
    logic [ADDR_WIDTH-1:0] w_dedAddr;
    logic                  r_ovfFlag;

    scrubState_e           r_state;
    scrubState_e           w_nextState;
    logic [INT_W-1:0]      r_intCnt;
    logic [ADDR_WIDTH-1:0] r_scrubAddr;
    logic                  w_intDone;
    logic                  w_sweepLast;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_portAddr[i] = raddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_portData[i] = rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A report only counts when the port really read something; port C also
    // reads on behalf of the sweep. x0 is hardwired and never reported. DED
    // masks SEC on the same port.
    always_comb begin
        w_effRd[0] = rd_valid_i[0] && (w_portAddr[0] != '0);
        w_effRd[1] = rd_valid_i[1] && (w_portAddr[1] != '0);
        w_effRd[2] = (rd_valid_i[2] || scrub_re_o) && (w_portAddr[2] != '0);
        w_effSec   = w_effRd & sec_i & ~ded_i;
        w_effDed   = w_effRd & ded_i;
    end

    // Only the highest-priority SEC is a capture candidate; the others are
    // left to be found again on a later read or sweep.
    always_comb begin
        w_candValid = 1'b0;
        w_candAddr  = '0;
        w_candData  = '0;
        if (w_effSec[0]) begin
            w_candValid = 1'b1;
            w_candAddr  = w_portAddr[0];
            w_candData  = w_portData[0];
        end else if (w_effSec[1]) begin
            w_candValid = 1'b1;
            w_candAddr  = w_portAddr[1];
            w_candData  = w_portData[1];
        end else if (w_effSec[2]) begin
            w_candValid = 1'b1;
            w_candAddr  = w_portAddr[2];
            w_candData  = w_portData[2];
        end
    end

    // Core writes kill matching pending entries so a stale correction never
    // overwrites newer core data. Only occupied slots carry a valid bit.
    always_comb begin
        w_kill        = '0;
        w_candPending = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_kill[k] = r_bufValid[k] &&
                        ((core_we_a_i && (core_waddr_a_i == r_bufAddr[k])) ||
                         (core_we_b_i && (core_waddr_b_i == r_bufAddr[k])));
            if (r_bufValid[k] && (r_bufAddr[k] == w_candAddr)) begin
                w_candPending = 1'b1;
            end
        end
    end

    assign w_candCoreHit = (core_we_a_i && (core_waddr_a_i == w_candAddr)) ||
                           (core_we_b_i && (core_waddr_b_i == w_candAddr));
    assign w_enqReq      = w_candValid && !w_candPending && !w_candCoreHit;

    // The head also counts as dead when it is being killed this very cycle.
    assign w_headLive = r_bufValid[r_head] && !w_kill[r_head];
    assign w_pop      = (r_count != '0) && (!w_headLive || !core_we_b_i);
    assign w_full     = (r_count == OCC_W'(DEPTH));
    assign w_push     = w_enqReq && (!w_full || w_pop);
    assign w_drop     = w_enqReq && w_full && !w_pop;

    // When full with a same-cycle pop, tail equals head: the push must win.
    always_comb begin
        w_validNext = r_bufValid & ~w_kill;
        if (w_pop) begin
            w_validNext[r_head] = 1'b0;
        end
        if (w_push) begin
            w_validNext[r_tail] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_bufAddr[k] <= '0;
                r_bufData[k] <= '0;
            end
            r_bufValid <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_bufValid <= w_validNext;
            if (w_push) begin
                r_bufAddr[r_tail] <= w_candAddr;
                r_bufData[r_tail] <= w_candData;
                r_tail            <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
        end
    end

    assign wb_we_o    = w_headLive && !core_we_b_i;
    assign wb_waddr_o = r_bufAddr[r_head];
    assign wb_wdata_o = r_bufData[r_head];

    assign w_secSum  = {1'b0, r_secCnt} + (CNT_WIDTH+1)'(w_effSec[0])
                     + (CNT_WIDTH+1)'(w_effSec[1]) + (CNT_WIDTH+1)'(w_effSec[2]);
    assign w_secNext = w_secSum[CNT_WIDTH] ? '1 : w_secSum[CNT_WIDTH-1:0];

    always_comb begin
        w_dedAddr = '0;
        if (w_effDed[0]) begin
            w_dedAddr = w_portAddr[0];
        end else if (w_effDed[1]) begin
            w_dedAddr = w_portAddr[1];
        end else if (w_effDed[2]) begin
            w_dedAddr = w_portAddr[2];
        end
    end

    // Clear beats any same-cycle update of the statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_secCnt  <= '0;
            r_dedFlag <= 1'b0;
            r_dedAddr <= '0;
            r_ovfFlag <= 1'b0;
        end else if (clear_i) begin
            r_secCnt  <= '0;
            r_dedFlag <= 1'b0;
            r_dedAddr <= '0;
            r_ovfFlag <= 1'b0;
        end else begin
            r_secCnt <= w_secNext;
            if (w_drop) begin
                r_ovfFlag <= 1'b1;
            end
            if (|w_effDed) begin
                r_dedFlag <= 1'b1;
                if (!r_dedFlag) begin
                    r_dedAddr <= w_dedAddr;
                end
            end
        end
    end

    assign sec_count_o = r_secCnt;
    assign ded_flag_o  = r_dedFlag;
    assign ded_addr_o  = r_dedAddr;
    assign ovf_flag_o  = r_ovfFlag;

    // Scrub FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    assign w_intDone   = (r_intCnt == INT_W'(SCRUB_INTERVAL - 1));
    assign w_sweepLast = scrub_re_o && (r_scrubAddr == ADDR_WIDTH'(NUM_REGS - 1));

    // Scrub FSM: next state. Disabling the sweep aborts it immediately.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (scrub_en_i && w_intDone) begin
                    w_nextState = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (!scrub_en_i || w_sweepLast) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Scrub FSM: outputs. The sweep yields port C to the core.
    always_comb begin
        scrub_re_o   = 1'b0;
        scrub_busy_o = 1'b0;
        if (r_state == S_SWEEP) begin
            scrub_re_o   = !port_c_busy_i;
            scrub_busy_o = 1'b1;
        end
    end

    // Interval counter holds while the sweep is disabled; the address only
    // advances on cycles where the sweep actually got port C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_intCnt    <= '0;
            r_scrubAddr <= '0;
        end else if (r_state == S_IDLE) begin
            if (scrub_en_i) begin
                if (w_intDone) begin
                    r_intCnt    <= '0;
                    r_scrubAddr <= ADDR_WIDTH'(1);
                end else begin
                    r_intCnt <= r_intCnt + INT_W'(1);
                end
            end
        end else begin
            if (!scrub_en_i || w_sweepLast) begin
                r_intCnt    <= '0;
                r_scrubAddr <= '0;
            end else if (scrub_re_o) begin
                r_scrubAddr <= r_scrubAddr + ADDR_WIDTH'(1);
            end
        end
    end

    assign scrub_raddr_o = r_scrubAddr;

endmodule
